// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the synchronous data memory.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_t;

  localparam int DMEM_DATA_WIDTH = 8;
  localparam int DMEM_DEPTH      = 256;
  localparam int DMEM_ADDR_WIDTH = 8;

endpackage

// File: rtl/dmem_array.sv
// Storage array: one write port, registered read with bypass, optional even-parity bit.
// Optional feature: DMEM_PARITY_EN adds the stored parity bit and a read-side parity check.
module dmem_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef DMEM_PARITY_EN
  input  logic                  wpar,
  output logic                  perr,
`endif
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] bypass_dat,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef DMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= wpar;
  end

  // Stored bit makes the word+parity XOR to zero; any odd flip shows as 1.
  assign perr = ^{mem[raddr], par_mem[raddr]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= bypass ? bypass_dat : mem[raddr];
    end
  end

endmodule

// File: rtl/data_memory_sync.sv
// Single-port data RAM with registered read, write-first forwarding and a post-reset clear sweep.
// Optional feature: DMEM_PARITY_EN adds per-word even parity and a sticky par_err output.
module data_memory_sync
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  RD,
  input  logic                  WR,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rd_valid,
  output logic                  busy
`ifdef DMEM_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  dmem_state_t           state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  clearing;
  logic                  in_range;
  logic                  rd_req;
  logic                  wr_req;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] bypass_dat;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;

  assign clearing = (state == ST_CLEAR);
  assign in_range = (int'(address) < DEPTH);
  assign rd_req   = !clearing && RD;
  assign wr_req   = !clearing && WR && in_range;

  // Out-of-range reads return zero; a same-edge write is forwarded (write-first).
  assign bypass     = !in_range || WR;
  assign bypass_dat = in_range ? dataIn : '0;

  assign arr_we    = clearing || wr_req;
  assign arr_waddr = clearing ? cnt : address;
  assign arr_wdata = clearing ? '0 : dataIn;

`ifdef DMEM_PARITY_EN
  logic arr_wpar;
  logic arr_perr;
  assign arr_wpar = clearing ? 1'b0 : ^dataIn;
`endif

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (arr_we),
    .waddr     (arr_waddr),
    .wdata     (arr_wdata),
`ifdef DMEM_PARITY_EN
    .wpar      (arr_wpar),
    .perr      (arr_perr),
`endif
    .re        (rd_req),
    .raddr     (address),
    .bypass    (bypass),
    .bypass_dat(bypass_dat),
    .rdata     (dataOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      busy     <= 1'b1;
      rd_valid <= 1'b0;
`ifdef DMEM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_CLEAR: begin
          rd_valid <= 1'b0;
          if (cnt == LAST_ADDR) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_READY: begin
          rd_valid <= RD;
`ifdef DMEM_PARITY_EN
          if (rd_req && !bypass && arr_perr) par_err <= 1'b1;
`endif
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench: full-depth instance plus a DEPTH=200 instance sharing stimulus.
module tb_data_memory_sync;

  logic       clk;
  logic       rst_n;
  logic [7:0] address;
  logic [7:0] dataIn;
  logic       RD;
  logic       WR;
  logic [7:0] dout0, dout1;
  logic       vld0, vld1;
  logic       busy0, busy1;
`ifdef DMEM_PARITY_EN
  logic       perr0, perr1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  data_memory_sync #(.DATA_WIDTH(8), .DEPTH(256), .ADDR_WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .address(address), .dataIn(dataIn), .RD(RD), .WR(WR),
    .dataOut(dout0), .rd_valid(vld0), .busy(busy0)
`ifdef DMEM_PARITY_EN
    , .par_err(perr0)
`endif
  );

  data_memory_sync #(.DATA_WIDTH(8), .DEPTH(200), .ADDR_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .address(address), .dataIn(dataIn), .RD(RD), .WR(WR),
    .dataOut(dout1), .rd_valid(vld1), .busy(busy1)
`ifdef DMEM_PARITY_EN
    , .par_err(perr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One rising edge; return on the following falling edge for stable sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    RD = rd; WR = wr; address = a; dataIn = d;
  endtask

  // Counts edges after release until each instance drops busy; bounded.
  task automatic sweep(output int fall0, output int fall1);
    fall0 = 0; fall1 = 0;
    for (int e = 1; e <= 300; e++) begin
      step();
      if (vld0 !== 1'b0 && fall0 == 0) fall0 = -1;
      if (!busy0 && fall0 == 0) fall0 = e;
      if (!busy1 && fall1 == 0) fall1 = e;
      if (fall0 != 0 && fall1 != 0) break;
    end
  endtask

  int f0, f1;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("reset busy", busy0, 1);
    check("reset dataOut", dout0, 0);
    check("reset rd_valid", vld0, 0);

    rst_n = 1'b1;
    sweep(f0, f1);
    check("sweep edges d256", f0, 256);
    check("sweep edges d200", f1, 200);

    // Back-to-back reads of cleared words.
    drive(1, 0, 8'h00, 8'h00); step();
    check("rd 0x00", dout0, 8'h00);
    check("rd 0x00 valid", vld0, 1);
    drive(1, 0, 8'd127, 8'h00); step();
    check("rd 0x7F", dout0, 8'h00);
    check("rd 0x7F valid b2b", vld0, 1);
    drive(1, 0, 8'd255, 8'h00); step();
    check("rd 0xFF", dout0, 8'h00);

    // Write then read next edge.
    drive(0, 1, 8'h10, 8'hA5); step();
    check("write-only no valid", vld0, 0);
    drive(1, 0, 8'h10, 8'h00); step();
    check("rd 0x10 data", dout0, 8'hA5);
    check("rd 0x10 valid", vld0, 1);
    drive(0, 0, 8'h10, 8'h00); step();
    check("idle valid low", vld0, 0);
    check("idle dataOut holds", dout0, 8'hA5);

    // Simultaneous read and write forwards the new data.
    drive(1, 1, 8'h20, 8'h3C); step();
    check("rw fwd data", dout0, 8'h3C);
    check("rw fwd valid", vld0, 1);
    drive(1, 0, 8'h20, 8'h00); step();
    check("rd 0x20 after rw", dout0, 8'h3C);

    // 0xF0 is beyond DEPTH=200 but inside DEPTH=256.
    drive(0, 1, 8'hF0, 8'hFF); step();
    drive(1, 0, 8'hF0, 8'h00); step();
    check("oor rd data d200", dout1, 8'h00);
    check("oor rd valid d200", vld1, 1);
    check("in-range rd d256", dout0, 8'hFF);
    drive(1, 1, 8'hF1, 8'h77); step();
    check("oor rw data d200", dout1, 8'h00);
    check("rw fwd d256", dout0, 8'h77);

    // Reset mid-operation, then again mid-sweep.
    drive(0, 1, 8'h05, 8'h55); step();
    drive(1, 0, 8'h05, 8'h00); step();
    check("rd 0x05", dout0, 8'h55);
    drive(0, 0, 8'h00, 8'h00);
    rst_n = 1'b0; #1;
    check("async rst dataOut", dout0, 0);
    check("async rst rd_valid", vld0, 0);
    check("async rst busy", busy0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) step();
    rst_n = 1'b0; #1;
    check("rst mid-sweep busy", busy0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    // Requests during the sweep must be ignored (0x30 is cleared early, so a late write would stick).
    drive(1, 1, 8'h30, 8'h77);
    sweep(f0, f1);
    check("resweep edges d256", f0, 256);
    drive(1, 0, 8'h05, 8'h00); step();
    check("rd 0x05 after resweep", dout0, 8'h00);
    drive(1, 0, 8'h30, 8'h00); step();
    check("busy write ignored", dout0, 8'h00);
    check("rd 0x30 valid", vld0, 1);

`ifdef DMEM_PARITY_EN
    drive(0, 1, 8'h08, 8'h0B); step();
    drive(1, 0, 8'h08, 8'h00); step();
    check("par clean read", perr0, 0);
    dut0.u_array.par_mem[8] = ~dut0.u_array.par_mem[8];
    drive(1, 0, 8'h08, 8'h00); step();
    check("par_err with valid", {perr0, vld0}, 2'b11);
    drive(1, 0, 8'h09, 8'h00); step();
    check("par_err sticky", perr0, 1);
    drive(0, 0, 8'h00, 8'h00);
    rst_n = 1'b0; #1;
    check("par_err reset", perr0, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_sync.md
# data_memory_sync

Parametrised synchronous data memory for the processor datapath: single port, registered read, write-first forwarding. After every reset it runs a hardware clear sweep that zeroes all locations, so software never reads stale contents. The processor core uses it as its data RAM and must stall on `busy`. Read data carries a `rd_valid` strobe.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width in bits.
- `DEPTH`, 256, number of words; must satisfy 2 ≤ `DEPTH` ≤ 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 8, address bus width.

Ports:
- `clk`  in  1  clock; all activity on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `address`  in  `ADDR_WIDTH`  word address for read and write.
- `dataIn`  in  `DATA_WIDTH`  write data.
- `RD`  in  1  read request, sampled on the rising edge.
- `WR`  in  1  write request, sampled on the rising edge.
- `dataOut`  out  `DATA_WIDTH`  registered read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse when `dataOut` carries a new read result.
- `busy`  out  1  clear sweep in progress; `RD` and `WR` are ignored while this is high.
- `par_err`  out  1  parity error flag; present only with `DMEM_PARITY_EN`.

## Operation
- Reset values: `dataOut`=0, `rd_valid`=0, `busy`=1, `par_err`=0, sweep counter=0, state=`ST_CLEAR`.
- `ST_CLEAR`:
  - Each edge writes 0 to location at counter, then increments the counter.
  - After the edge that writes `DEPTH`-1, moves to `ST_READY` and `busy` drops to 0.
- `ST_READY`:
  - `WR`=1 writes `dataIn` to `address`.
  - `RD`=1 loads `dataOut` with the word at `address`; `rd_valid`=1 for the next cycle.
- `RD` and `WR` both asserted: write-first. `dataOut` returns the new `dataIn`.
- `address` ≥ `DEPTH`: write is dropped; read returns 0 with `rd_valid`=1.
- `RD` and `WR` both 0: `dataOut` holds, `rd_valid`=0.
- Reset asserted mid-sweep or mid-operation: outputs go to reset values immediately. On release the sweep restarts from address 0, and all contents are treated as lost.
- Widths: counter is `ADDR_WIDTH` bits wide and never wraps past `DEPTH`-1.

## Timing
- Read latency 1: `RD` sampled at edge N → `dataOut`/`rd_valid` valid after edge N.
- Write latency 0: a read at edge N+1 sees the write made at edge N.
- Clear sweep takes exactly `DEPTH` edges after `rst_n` rises. `busy` falls after edge `DEPTH`, counting the first edge with `rst_n`=1 as edge 1.
- Requests on the edge where `busy` is still 1 are ignored and are not queued.
- Back-to-back reads are accepted every cycle; `rd_valid` stays high while reads continue.

## Configuration
- `DMEM_PARITY_EN` defined:
  - Each word stores one extra even-parity bit, computed on write.
  - The sweep writes parity 0.
  - On read, a parity mismatch sets `par_err`=1 in the same cycle as `rd_valid`.
  - `par_err` is sticky until reset.
- `DMEM_PARITY_EN` undefined: no parity storage, no `par_err` port.

## Structure
- Package `dmem_pkg` holds:
  - state enum `dmem_state_t` {`ST_CLEAR`, `ST_READY`};
  - default constants `DMEM_DATA_WIDTH`=8, `DMEM_DEPTH`=256, `DMEM_ADDR_WIDTH`=8.
- Sub-module `dmem_array`: the storage array with write port, registered read and optional parity bit.
- Top level holds the clear FSM, sweep counter, range check, forwarding and `rd_valid` logic.

## Test plan
- Reset, then hold `RD`/`WR` low: `busy`=1 for 256 edges then 0. Reading addresses 0, 127 and 255 returns 0x00.
- `WR` 0xA5 to 0x10, then `RD` 0x10 on the next edge: `dataOut`=0xA5 with a `rd_valid` pulse exactly one cycle later.
- `RD`+`WR` 0x3C to 0x20 on the same edge: `dataOut`=0x3C.
- With `DEPTH`=200: `WR` 0xFF to 0xF0, then `RD` 0xF0: `dataOut`=0x00 and `rd_valid`=1.
- Assert `rst_n` at sweep count 100 after writing 0x55 to 0x05: outputs reset, full 256-cycle sweep reruns, read of 0x05 returns 0x00.
- `DMEM_PARITY_EN`: force a parity bit flip at address 0x08, then `RD` 0x08: `par_err` rises with `rd_valid` and stays 1 until reset.
